obuf_mc: RTL and testbench
==========================

# obuf_mc

Multi-channel output buffer for the systolic conv array: collects results from NUM_CH PE output channels into a single synchronous FIFO and presents them to the downstream reader with a channel tag. Successor to the fixed 3-channel, 9-entry output FIFO. Parametrised channel count, width and non-power-of-2 depth. Simultaneous channel writes are resolved by round-robin arbitration with per-channel backpressure instead of being flagged as a timing error.

## Interface
- DATA_W, 16, result word width (2x 8-bit operand width)
- NUM_CH, 3, number of PE output channels (>=1)
- DEPTH, 9, FIFO entries (>=2, any integer)
- AF_LVL, DEPTH-1, almost_full threshold on count
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- ch_valid  in  NUM_CH  per-channel write request
- ch_data  in  NUM_CH*DATA_W  channel i data at [i*DATA_W +: DATA_W]
- ch_ready  out  NUM_CH  per-channel accept, at most one bit set
- rd_en  in  1  read request
- rd_data  out  DATA_W  registered read data
- rd_ch  out  CH_W  channel index of rd_data, CH_W = max(1, clog2(NUM_CH))
- rd_valid  out  1  rd_data/rd_ch updated this cycle
- empty  out  1  no entries
- full  out  1  DEPTH entries
- almost_full  out  1  count >= AF_LVL
- count  out  clog2(DEPTH+1)  current occupancy
- err  out  1  sticky error flag (see Configuration)

## Operation
- Storage: DEPTH entries of {channel index, data}. Write and read pointers are addr + wrap bit; at addr DEPTH-1 the pointer goes to addr 0 with the wrap bit toggled.
- empty = pointers equal. full = addresses equal and wrap bits differ. count is a registered counter, consistent with the pointers every cycle.
- Arbitration: round-robin among asserted ch_valid, starting from priority pointer rr_ptr (reset 0).
  - Grant: first valid channel at or after rr_ptr, modulo NUM_CH.
  - ch_ready[g] = grant[g] & !full. This is combinational from ch_valid, full and rr_ptr. All bits are 0 when no valid request or when full.
  - Accept: ch_valid[g] & ch_ready[g]. The entry {g, ch_data[g]} is written at wr_addr. After an accept, rr_ptr = (g+1) mod NUM_CH. No accept leaves rr_ptr unchanged.
  - A non-granted channel holds ch_valid and ch_data stable until accepted. No data is lost or duplicated.
- Read: rd_en & !empty pops the entry at rd_addr. rd_data and rd_ch load and rd_valid = 1 next cycle. Otherwise rd_valid = 0 and rd_data/rd_ch hold.
- Simultaneous events:
  - Write and read when neither full nor empty: both proceed; count unchanged.
  - When full: read proceeds; write is blocked this cycle because ready is computed from the current full.
  - When empty: write proceeds; read is ignored (rd_valid = 0).
- Reset, any time including mid-transfer:
  - Pointers, count and rr_ptr go to 0.
  - empty = 1; full = 0; almost_full = 0.
  - rd_data = 0, rd_ch = 0, rd_valid = 0, err = 0.
  - ch_ready is forced to 0 while rst is high.
  - Memory contents are not reset.

## Timing
- Write-to-read latency: an entry written at edge N is readable (empty = 0) after edge N. With rd_en high in cycle N+1, rd_data is valid after edge N+2.
- Read latency: 1 cycle from rd_en to rd_valid.
- Sustained throughput: 1 write and 1 read per cycle.
- Round-robin fairness: a continuously requesting channel is accepted within NUM_CH accepts.
- Status outputs change only on clock edges; ch_ready is the only combinational output.

## Configuration
- OBUF_MC_ERR_EN defined:
  - err sets on rd_en while empty (underflow).
  - err also sets on any ch_valid bit dropping while that channel has not yet been accepted (protocol violation).
  - err is sticky until rst.
- Undefined: no checking logic is built and err is tied to 0.

## Structure
- Package obuf_mc_pkg holds:
  - the clog2 function,
  - default DATA_W / NUM_CH / DEPTH,
  - the CH_W derivation,
  - the entry layout constants (tag field width and offsets).
- Sub-module obuf_rr_arb is parametrised by NUM_CH:
  - inputs: req vector and rr_ptr;
  - outputs: one-hot grant and encoded index;
  - purely combinational.
- Pointer, counter, memory and read register logic live in the top.

## Test plan
- Single channel fill: NUM_CH=3, DEPTH=9; ch1 writes 0x0001..0x0009 → full = 1 after the 9th accept and ch_ready = 0; a 10th request is held; nine reads return 0x0001..0x0009 in order with rd_ch = 1.
- Collision: ch_valid = 3'b111 for 3 cycles from reset, data 0xA0/0xB1/0xC2 → accepted in order ch0, ch1, ch2; reads return tags 0, 1, 2.
- Wrap-around: DEPTH=5, 13 writes interleaved with reads keeping count in 1..4 → data and order intact across two pointer wraps; full is never falsely asserted.
- Full with simultaneous read/write: fill to 9, then rd_en = 1 and ch0 valid → the read pops and the write is blocked that cycle; the write is accepted next cycle; count goes 9 → 8 → 9.
- Reset mid-operation: count = 4, assert rst asynchronously between edges → immediately count = 0, empty = 1, rd_valid = 0, ch_ready = 0; after release, the first write lands at addr 0.
- OBUF_MC_ERR_EN: rd_en on empty → err = 1 after the next edge and it stays 1 until rst. Without the macro, err = 0 throughout.

Source files
------------

// File: rtl/obuf_mc_pkg.sv
// Shared constants and helpers for the multi-channel output buffer.
// Entry layout in storage: {channel tag, data word}, data at bit 0.
package obuf_mc_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_NUM_CH = 3;
    localparam int DEF_DEPTH  = 9;

    // Ceiling log2. Returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

    // Channel tag width. It is never narrower than one bit, so a single channel still has a field.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? clog2(num_ch) : 1;
    endfunction

    // Entry layout: data occupies [DATA_LSB +: data_w], tag sits directly above it.
    localparam int DATA_LSB = 0;

    function automatic int tag_lsb(input int data_w);
        return DATA_LSB + data_w;
    endfunction

    function automatic int entry_w(input int data_w, input int num_ch);
        return data_w + ch_w(num_ch);
    endfunction

endpackage

// File: rtl/obuf_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or
// after rr_ptr, wrapping modulo NUM_CH. Produces one-hot and encoded grant.
module obuf_rr_arb
    import obuf_mc_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   rr_ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    // Two passes: first the channels at or above the pointer, then the ones below it.
    always_comb begin
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req[i] && (i >= int'(rr_ptr))) begin
                grant[i]  = 1'b1;
                grant_idx = CH_W'(i);
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req[i] && (i < int'(rr_ptr))) begin
                grant[i]  = 1'b1;
                grant_idx = CH_W'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/obuf_mc.sv
// Multi-channel output buffer: NUM_CH producer channels, round-robin
// arbitrated into one synchronous FIFO of DEPTH {tag, data} entries.
// Optional checking (sticky err) is built when OBUF_MC_ERR_EN is defined.
module obuf_mc
    import obuf_mc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_LVL = DEPTH - 1,
    localparam int CH_W  = ch_w(NUM_CH),
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_ready,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [CH_W-1:0]          rd_ch,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [CNT_W-1:0]         count,
    output logic                     err
);

    localparam int AW   = clog2(DEPTH);
    localparam int EW   = entry_w(DATA_W, NUM_CH);
    localparam int TLSB = tag_lsb(DATA_W);

    logic [AW-1:0]     wr_addr, rd_addr;
    logic              wr_wrap, rd_wrap;
    logic [CH_W-1:0]   rr_ptr, gnt_idx;
    logic [NUM_CH-1:0] gnt, acc_vec;
    logic              wr_fire, rd_fire;
    logic [DATA_W-1:0] wr_word;
    logic [EW-1:0]     mem [DEPTH];

    // Pointer advance with wrap-bit toggle at the last address (depth need not be a power of 2).
    function automatic logic [AW:0] ptr_inc(input logic [AW-1:0] a, input logic w);
        if (a == AW'(DEPTH - 1)) return {~w, {AW{1'b0}}};
        else                     return {w, a + AW'(1)};
    endfunction

    obuf_rr_arb #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
        .req       (ch_valid),
        .rr_ptr    (rr_ptr),
        .grant     (gnt),
        .grant_idx (gnt_idx)
    );

    assign empty       = (wr_addr == rd_addr) && (wr_wrap == rd_wrap);
    assign full        = (wr_addr == rd_addr) && (wr_wrap != rd_wrap);
    assign almost_full = (count >= CNT_W'(AF_LVL));
    // Ready is masked by reset too, so no channel sees an accept while rst is high.
    assign ch_ready    = (rst || full) ? '0 : gnt;
    assign acc_vec     = ch_valid & ch_ready;
    assign wr_fire     = |acc_vec;
    assign rd_fire     = rd_en & ~empty;
    assign wr_word     = ch_data[gnt_idx * DATA_W +: DATA_W];

    // Control state: pointers, occupancy counter and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr <= '0;
            wr_wrap <= 1'b0;
            rd_addr <= '0;
            rd_wrap <= 1'b0;
            count   <= '0;
            rr_ptr  <= '0;
        end else begin
            if (wr_fire) begin
                {wr_wrap, wr_addr} <= ptr_inc(wr_addr, wr_wrap);
                rr_ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
            end
            if (rd_fire) {rd_wrap, rd_addr} <= ptr_inc(rd_addr, rd_wrap);
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_addr] <= {gnt_idx, wr_word};
    end

    // Read register: loads on a successful pop, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_ch    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= mem[rd_addr][DATA_LSB +: DATA_W];
                rd_ch   <= mem[rd_addr][TLSB +: CH_W];
            end
        end
    end

`ifdef OBUF_MC_ERR_EN
    logic [NUM_CH-1:0] pend_q;

    // Sticky error: underflow read, or a request withdrawn before it was accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            err    <= 1'b0;
        end else begin
            pend_q <= ch_valid & ~acc_vec;
            if ((rd_en && empty) || |(pend_q & ~ch_valid)) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_obuf_mc.sv
// Directed testbench for obuf_mc (NUM_CH=3, DATA_W=16, DEPTH=9).
module tb_obuf_mc;

    localparam int DATA_W = 16;
    localparam int NUM_CH = 3;
`ifdef OBUF_MC_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_ready;
    logic                     rd_en;
    logic [DATA_W-1:0]        rd_data;
    logic [1:0]               rd_ch;
    logic                     rd_valid, empty, full, almost_full, err;
    logic [3:0]               count;

    int errors = 0;
    int checks = 0;

    obuf_mc #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(9)) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_valid    (ch_valid),
        .ch_data     (ch_data),
        .ch_ready    (ch_ready),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_ch       (rd_ch),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; ch_valid = 3'b111; ch_data = '0; rd_en = 1'b0;
        repeat (2) tick();
        check("rst_ready", ch_ready, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_af", almost_full, 0);
        check("rst_rdvalid", rd_valid, 0);
        check("rst_err", err, 0);
        ch_valid = 3'b000;
        rst = 1'b0;
        tick();

        // Collision: all three request together, served ch0, ch1, ch2
        ch_data = {16'h00C2, 16'h00B1, 16'h00A0};
        ch_valid = 3'b111; #1 check("coll_rdy0", ch_ready, 3'b001);
        tick();
        ch_valid = 3'b110; #1 check("coll_rdy1", ch_ready, 3'b010);
        tick();
        ch_valid = 3'b100; #1 check("coll_rdy2", ch_ready, 3'b100);
        tick();
        ch_valid = 3'b000;
        check("coll_count", count, 3);
        rd_en = 1'b1;
        tick();
        check("coll_rv0", rd_valid, 1);
        check("coll_d0", rd_data, 16'h00A0);
        check("coll_t0", rd_ch, 0);
        tick();
        check("coll_d1", rd_data, 16'h00B1);
        check("coll_t1", rd_ch, 1);
        tick();
        check("coll_d2", rd_data, 16'h00C2);
        check("coll_t2", rd_ch, 2);
        rd_en = 1'b0;
        tick();
        check("coll_rv_off", rd_valid, 0);
        check("coll_hold", rd_data, 16'h00C2);
        check("coll_empty", empty, 1);

        // Single channel fill: ch1 writes 1..9
        for (int i = 1; i <= 9; i++) begin
            ch_data[DATA_W +: DATA_W] = 16'(i);
            ch_valid = 3'b010;
            #1 check("fill_rdy", ch_ready, 3'b010);
            tick();
            if (i == 7) check("fill_af7", almost_full, 0);
            if (i == 8) begin
                check("fill_af8", almost_full, 1);
                check("fill_full8", full, 0);
            end
        end
        check("fill_count", count, 9);
        check("fill_full", full, 1);
        ch_data[DATA_W +: DATA_W] = 16'd10;
        #1 check("full_rdy", ch_ready, 0);
        tick();
        check("full_held_count", count, 9);

        // Full with simultaneous read and write: read pops, write waits a cycle
        rd_en = 1'b1;
        #1 check("fullrw_rdy", ch_ready, 0);
        tick();
        check("fullrw_count8", count, 8);
        check("fullrw_d", rd_data, 1);
        check("fullrw_t", rd_ch, 1);
        check("fullrw_full", full, 0);
        rd_en = 1'b0;
        #1 check("fullrw_rdy2", ch_ready, 3'b010);
        tick();
        check("fullrw_count9", count, 9);
        check("fullrw_full9", full, 1);
        ch_valid = 3'b000;
        rd_en = 1'b1;
        for (int k = 2; k <= 10; k++) begin
            tick();
            check("drain_d", rd_data, k);
            check("drain_t", rd_ch, 1);
        end
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);
        tick();
        check("under_rv", rd_valid, 0);
        check("under_hold", rd_data, 10);
        check("under_err", err, ERR_ON);
        rd_en = 1'b0;
        tick();
        check("under_err_sticky", err, ERR_ON);

        // Wrap-around: 20 writes from ch2 streamed through at count 1
        ch_data = {16'h0100, 32'h0};
        ch_valid = 3'b100;
        tick();
        rd_en = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            ch_data = {16'(16'h0100 + i), 32'h0};
            #1 check("wrap_rdy", ch_ready, 3'b100);
            tick();
            check("wrap_d", rd_data, 32'h100 + i - 1);
            check("wrap_t", rd_ch, 2);
            check("wrap_count", count, 1);
            check("wrap_full", full, 0);
        end
        ch_valid = 3'b000;
        tick();
        check("wrap_last", rd_data, 16'h0113);
        check("wrap_count0", count, 0);
        rd_en = 1'b0;

        // Fairness: ch0 and ch2 alternate
        ch_data = {16'h0052, 16'h0000, 16'h0050};
        ch_valid = 3'b101;
        #1 check("rr_rdy0", ch_ready, 3'b001);
        tick();
        ch_data[0 +: DATA_W] = 16'h0051;
        #1 check("rr_rdy2", ch_ready, 3'b100);
        tick();
        ch_valid = 3'b001;
        #1 check("rr_rdy0b", ch_ready, 3'b001);
        tick();
        ch_valid = 3'b010;
        ch_data[DATA_W +: DATA_W] = 16'h0077;
        tick();
        check("rr_count4", count, 4);
        ch_data[DATA_W +: DATA_W] = 16'h0078;
        rd_en = 1'b1;
        tick();
        check("rr_rw_count", count, 4);
        check("rr_rd_d", rd_data, 16'h0050);
        check("rr_rd_t", rd_ch, 0);
        rd_en = 1'b0;
        ch_valid = 3'b001;
        #1 check("rr_rdy_wrap", ch_ready, 3'b001);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        check("arst_full", full, 0);
        check("arst_af", almost_full, 0);
        check("arst_rv", rd_valid, 0);
        check("arst_d", rd_data, 0);
        check("arst_t", rd_ch, 0);
        check("arst_rdy", ch_ready, 0);
        check("arst_err", err, 0);
        tick();
        rst = 1'b0;
        ch_data[0 +: DATA_W] = 16'h0099;
        #1 check("post_rdy", ch_ready, 3'b001);
        tick();
        ch_valid = 3'b000;
        check("post_count", count, 1);
        rd_en = 1'b1;
        tick();
        check("post_d", rd_data, 16'h0099);
        check("post_t", rd_ch, 0);
        rd_en = 1'b0;
        tick();
        check("post_empty", empty, 1);
        check("post_err", err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
